// File: rtl/data_path_param.sv
// K&S processor datapath: PC, IR, 4-entry register file, ALU, flags register
// and instruction decode. Data width and RAM address width are parameters.

package k_and_s_pkg;
  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_LOAD   = 4'd1,
    I_STORE  = 4'd2,
    I_MOVE   = 4'd3,
    I_ADD    = 4'd4,
    I_SUB    = 4'd5,
    I_AND    = 4'd6,
    I_OR     = 4'd7,
    I_BRANCH = 4'd8,
    I_BZERO  = 4'd9,
    I_BNZERO = 4'd10,
    I_BNEG   = 4'd11,
    I_BNNEG  = 4'd12,
    I_HALT   = 4'd13
  } decoded_instruction_type;
endpackage

module data_path_param
  import k_and_s_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    branch,
  input  logic                    pc_enable,
  input  logic                    ir_enable,
  input  logic                    addr_sel,
  input  logic                    c_sel,
  input  logic [1:0]              operation,
  input  logic                    write_reg_enable,
  input  logic                    flags_reg_enable,
  output decoded_instruction_type decoded_instruction,
  output logic                    zero_op,
  output logic                    neg_op,
  output logic                    unsigned_overflow,
  output logic                    signed_overflow,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       data_out,
  input  logic [DATA_W-1:0]       data_in
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [DATA_W-1:0] rf_q [4];
  logic [DATA_W-1:0] rf_d [4];
  logic [3:0]        flags_q, flags_d;   // {zero, neg, unsigned_ovf, signed_ovf}

  logic [1:0]        a_addr_s, b_addr_s, c_addr_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] bus_a_s, bus_b_s, bus_c_s, alu_out_s;
  logic [DATA_W:0]   add_s, sub_s;
  logic              alu_uovf_s, alu_sovf_s;
  logic              unused_ir_s;

  // IR bit 7 is never a field for any instruction.
  assign unused_ir_s = ir_q[7];

  // Decode the current instruction; every field gets a default first.
  always_comb begin
    decoded_instruction = I_NOP;
    a_addr_s            = 2'd0;
    b_addr_s            = 2'd0;
    c_addr_s            = 2'd0;
    mem_addr_s          = '0;
    case (ir_q[15:8])
      8'h00: decoded_instruction = I_NOP;
      8'h81: begin
        decoded_instruction = I_LOAD;
        c_addr_s            = ir_q[6:5];
        mem_addr_s          = ir_q[ADDR_W-1:0];
      end
      8'h82: begin
        decoded_instruction = I_STORE;
        a_addr_s            = ir_q[6:5];
        mem_addr_s          = ir_q[ADDR_W-1:0];
      end
      8'h91: begin
        decoded_instruction = I_MOVE;
        a_addr_s            = ir_q[1:0];
        b_addr_s            = ir_q[1:0];
        c_addr_s            = ir_q[3:2];
      end
      8'hA1, 8'hA2, 8'hA3, 8'hA4: begin
        case (ir_q[10:8])
          3'd1:    decoded_instruction = I_ADD;
          3'd2:    decoded_instruction = I_SUB;
          3'd3:    decoded_instruction = I_AND;
          default: decoded_instruction = I_OR;
        endcase
        a_addr_s = ir_q[1:0];
        b_addr_s = ir_q[3:2];
        c_addr_s = ir_q[5:4];
      end
      8'h01: begin decoded_instruction = I_BRANCH; mem_addr_s = ir_q[ADDR_W-1:0]; end
      8'h02: begin decoded_instruction = I_BZERO;  mem_addr_s = ir_q[ADDR_W-1:0]; end
      8'h0B: begin decoded_instruction = I_BNZERO; mem_addr_s = ir_q[ADDR_W-1:0]; end
      8'h03: begin decoded_instruction = I_BNEG;   mem_addr_s = ir_q[ADDR_W-1:0]; end
      8'h0A: begin decoded_instruction = I_BNNEG;  mem_addr_s = ir_q[ADDR_W-1:0]; end
      8'hFF: decoded_instruction = I_HALT;
      default: decoded_instruction = I_NOP;
    endcase
  end

  assign bus_a_s  = rf_q[a_addr_s];
  assign bus_b_s  = rf_q[b_addr_s];
  assign bus_c_s  = c_sel ? alu_out_s : data_in;
  assign data_out = bus_a_s;
  assign ram_addr = addr_sel ? mem_addr_s : pc_q;

  assign add_s = {1'b0, bus_a_s} + {1'b0, bus_b_s};
  assign sub_s = {1'b0, bus_a_s} - {1'b0, bus_b_s};

  // ALU result and overflow flags; the extra top bit is carry (ADD) or borrow (SUB).
  always_comb begin
    alu_out_s  = '0;
    alu_uovf_s = 1'b0;
    alu_sovf_s = 1'b0;
    case (operation)
      2'b00: begin
        alu_out_s  = add_s[DATA_W-1:0];
        alu_uovf_s = add_s[DATA_W];
        alu_sovf_s = (bus_a_s[DATA_W-1] == bus_b_s[DATA_W-1]) &&
                     (add_s[DATA_W-1] != bus_a_s[DATA_W-1]);
      end
      2'b01: begin
        alu_out_s  = sub_s[DATA_W-1:0];
        alu_uovf_s = sub_s[DATA_W];
        alu_sovf_s = (bus_a_s[DATA_W-1] != bus_b_s[DATA_W-1]) &&
                     (sub_s[DATA_W-1] != bus_a_s[DATA_W-1]);
      end
      2'b10:   alu_out_s = bus_a_s & bus_b_s;
      default: alu_out_s = bus_a_s | bus_b_s;
    endcase
  end

  // Next-state for PC, IR, register file and flags from the control strobes.
  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    flags_d = flags_q;
    for (int i = 0; i < 4; i++) rf_d[i] = rf_q[i];
    if (pc_enable) begin
      pc_d = branch ? mem_addr_s : pc_q + ADDR_W'(1);
    end else begin
      pc_d = pc_q;
    end
    if (ir_enable) begin
      ir_d = data_in[15:0];
    end else begin
      ir_d = ir_q;
    end
    // c_addr_s comes from the old IR, so a simultaneous fetch does not redirect the write.
    if (write_reg_enable) begin
      rf_d[c_addr_s] = bus_c_s;
    end else begin
      rf_d[c_addr_s] = rf_q[c_addr_s];
    end
    if (flags_reg_enable) begin
      flags_d = {(alu_out_s == '0), alu_out_s[DATA_W-1], alu_uovf_s, alu_sovf_s};
    end else begin
      flags_d = flags_q;
    end
  end

  // State registers with asynchronous reset to the idle datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      ir_q    <= 16'h0000;
      flags_q <= 4'b0000;
      for (int i = 0; i < 4; i++) rf_q[i] <= '0;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
      for (int i = 0; i < 4; i++) rf_q[i] <= rf_d[i];
    end
  end

  assign zero_op           = flags_q[3];
  assign neg_op            = flags_q[2];
  assign unsigned_overflow = flags_q[1];
  assign signed_overflow   = flags_q[0];

endmodule

// File: tb/tb_data_path_param.sv
// Directed bench: a 16-bit/5-bit-address datapath and a 32-bit/4-bit-address
// datapath driven by the same control stimulus, each checked against
// hand-computed values.
module tb_data_path_param;
  import k_and_s_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, branch, pc_enable, ir_enable, addr_sel, c_sel;
  logic [1:0] operation;
  logic write_reg_enable, flags_reg_enable;
  logic [31:0] data_in;

  decoded_instruction_type dec16, dec32;
  logic z16, n16, u16, s16, z32, n32, u32, s32;
  logic [4:0]  ra16;
  logic [3:0]  ra32;
  logic [15:0] do16;
  logic [31:0] do32;

  int total = 0;
  int bad   = 0;

  data_path_param #(.DATA_W(16), .ADDR_W(5)) dut16 (
    .clk(clk), .rst(rst), .branch(branch), .pc_enable(pc_enable),
    .ir_enable(ir_enable), .addr_sel(addr_sel), .c_sel(c_sel),
    .operation(operation), .write_reg_enable(write_reg_enable),
    .flags_reg_enable(flags_reg_enable), .decoded_instruction(dec16),
    .zero_op(z16), .neg_op(n16), .unsigned_overflow(u16), .signed_overflow(s16),
    .ram_addr(ra16), .data_out(do16), .data_in(data_in[15:0])
  );

  data_path_param #(.DATA_W(32), .ADDR_W(4)) dut32 (
    .clk(clk), .rst(rst), .branch(branch), .pc_enable(pc_enable),
    .ir_enable(ir_enable), .addr_sel(addr_sel), .c_sel(c_sel),
    .operation(operation), .write_reg_enable(write_reg_enable),
    .flags_reg_enable(flags_reg_enable), .decoded_instruction(dec32),
    .zero_op(z32), .neg_op(n32), .unsigned_overflow(u32), .signed_overflow(s32),
    .ram_addr(ra32), .data_out(do32), .data_in(data_in)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [15:0] ir);
    ir_enable = 1'b1;
    data_in   = {16'h0000, ir};
    tick();
    ir_enable = 1'b0;
  endtask

  // LOAD into register r, then write v from data_in
  task automatic load_reg(input logic [1:0] r, input logic [31:0] v);
    fetch({8'h81, 1'b0, r, 5'h00});
    write_reg_enable = 1'b1;
    c_sel            = 1'b0;
    data_in          = v;
    tick();
    write_reg_enable = 1'b0;
  endtask

  // STORE from register r puts R[r] on data_out
  task automatic show_reg(input logic [1:0] r);
    fetch({8'h82, 1'b0, r, 5'h00});
  endtask

  task automatic alu_op(input logic [15:0] ir, input logic [1:0] op);
    fetch(ir);
    operation        = op;
    c_sel            = 1'b1;
    write_reg_enable = 1'b1;
    flags_reg_enable = 1'b1;
    tick();
    write_reg_enable = 1'b0;
    flags_reg_enable = 1'b0;
    c_sel            = 1'b0;
  endtask

  initial begin
    rst = 1'b1; branch = 1'b0; pc_enable = 1'b0; ir_enable = 1'b0;
    addr_sel = 1'b0; c_sel = 1'b0; operation = 2'b00;
    write_reg_enable = 1'b0; flags_reg_enable = 1'b0; data_in = 32'h0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // reset state
    check("rst_pc16",   {27'h0, ra16}, 32'h0);
    check("rst_dec16",  {28'h0, dec16}, {28'h0, I_NOP});
    check("rst_flags16", {28'h0, z16, n16, u16, s16}, 32'h0);
    check("rst_dout16", {16'h0, do16}, 32'h0);
    check("rst_dout32", do32, 32'h0);

    // LOAD fetch and register write
    fetch(16'h8102);
    check("load_dec", {28'h0, dec16}, {28'h0, I_LOAD});
    addr_sel = 1'b1; #1;
    check("load_addr16", {27'h0, ra16}, 32'd2);
    check("load_addr32", {28'h0, ra32}, 32'd2);
    addr_sel = 1'b0;
    write_reg_enable = 1'b1; data_in = 32'h0000_1234; tick(); write_reg_enable = 1'b0;
    show_reg(2'd0);
    check("load_r0", {16'h0, do16}, 32'h1234);

    // ADD 0xFFFF + 1: wraps to zero in 16 bits, not in 32 bits
    load_reg(2'd0, 32'h0000_FFFF);
    load_reg(2'd1, 32'h0000_0001);
    alu_op(16'hA124, 2'b00);
    check("add_wrap_flags16", {28'h0, z16, n16, u16, s16}, 32'b1010);
    check("add_wrap_flags32", {28'h0, z32, n32, u32, s32}, 32'b0000);
    show_reg(2'd2);
    check("add_wrap_r2_16", {16'h0, do16}, 32'h0);
    check("add_wrap_r2_32", do32, 32'h0001_0000);

    // ADD 0x7FFF + 1: signed overflow in 16 bits
    load_reg(2'd0, 32'h0000_7FFF);
    alu_op(16'hA124, 2'b00);
    check("add_sovf_flags16", {28'h0, z16, n16, u16, s16}, 32'b0101);
    check("add_sovf_flags32", {28'h0, z32, n32, u32, s32}, 32'b0000);
    show_reg(2'd2);
    check("add_sovf_r2", {16'h0, do16}, 32'h8000);

    // SUB 0 - 1: borrow, negative, no signed overflow
    load_reg(2'd0, 32'h0);
    alu_op(16'hA224, 2'b01);
    check("sub_flags16", {28'h0, z16, n16, u16, s16}, 32'b0110);
    check("sub_flags32", {28'h0, z32, n32, u32, s32}, 32'b0110);
    show_reg(2'd2);
    check("sub_r2_16", {16'h0, do16}, 32'hFFFF);
    check("sub_r2_32", do32, 32'hFFFF_FFFF);

    // PC: branch to 31, increment wraps to 0, branch to 7
    fetch(16'h011F);
    check("br_dec", {28'h0, dec16}, {28'h0, I_BRANCH});
    pc_enable = 1'b1; branch = 1'b1; tick();
    check("pc_31", {27'h0, ra16}, 32'd31);
    check("pc32_15", {28'h0, ra32}, 32'd15);
    branch = 1'b0; tick();
    check("pc_wrap16", {27'h0, ra16}, 32'd0);
    check("pc_wrap32", {28'h0, ra32}, 32'd0);
    pc_enable = 1'b0;
    fetch(16'h0107);
    pc_enable = 1'b1; branch = 1'b1; tick();
    pc_enable = 1'b0; branch = 1'b0;
    check("pc_br7", {27'h0, ra16}, 32'd7);

    // Decode corners
    fetch(16'h5500);
    check("dec_unknown", {28'h0, dec16}, {28'h0, I_NOP});
    fetch(16'hFF00);
    check("dec_halt", {28'h0, dec16}, {28'h0, I_HALT});
    fetch(16'h0B03);
    check("dec_bnzero", {28'h0, dec16}, {28'h0, I_BNZERO});

    // Fetch and write on the same edge: write goes to the old c (R1)
    fetch(16'h8120);
    ir_enable = 1'b1; write_reg_enable = 1'b1; c_sel = 1'b0; data_in = 32'h0000_8160;
    tick();
    ir_enable = 1'b0; write_reg_enable = 1'b0;
    check("sim_dec", {28'h0, dec16}, {28'h0, I_LOAD});
    show_reg(2'd1);
    check("sim_r1", {16'h0, do16}, 32'h8160);
    show_reg(2'd3);
    check("sim_r3", {16'h0, do16}, 32'h0);

    // MOVE R1 <- R3
    load_reg(2'd3, 32'hDEAD_BEEF);
    alu_op(16'h9107, 2'b11);
    check("move_dec_flags32", {28'h0, z32, n32, u32, s32}, 32'b0100);
    check("move_flags16", {28'h0, z16, n16, u16, s16}, 32'b0100);
    show_reg(2'd1);
    check("move_r1_32", do32, 32'hDEAD_BEEF);
    check("move_r1_16", {16'h0, do16}, 32'hBEEF);

    // Mid-program reset with pending updates
    show_reg(2'd1);
    pc_enable = 1'b1; branch = 1'b0; write_reg_enable = 1'b1;
    flags_reg_enable = 1'b1; c_sel = 1'b1; operation = 2'b11;
    #2 rst = 1'b1; #1;
    check("mrst_pc", {27'h0, ra16}, 32'd0);
    check("mrst_dec", {28'h0, dec16}, {28'h0, I_NOP});
    check("mrst_dout32", do32, 32'h0);
    tick();
    pc_enable = 1'b0; write_reg_enable = 1'b0; flags_reg_enable = 1'b0;
    #2 rst = 1'b0;
    tick();
    check("mrst_flags16", {28'h0, z16, n16, u16, s16}, 32'h0);
    check("mrst_pc_after", {27'h0, ra16}, 32'd0);
    show_reg(2'd1);
    check("mrst_r1", do32, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
